// File: rtl/half_adder_pkg.sv
// Default widths shared by the half adder slice.
// Lane count and statistics counter width.
package arith_pkg;

    localparam int HA_WIDTH     = 1;
    localparam int HA_CNT_WIDTH = 16;

endpackage

// File: rtl/half_adder_if.sv
// Operand/result bundle between a half adder and its user.
// The master drives operands and controls; the slave returns results.
interface half_adder_if
    import arith_pkg::*;
#(
    parameter int WIDTH     = HA_WIDTH,
    parameter int CNT_WIDTH = HA_CNT_WIDTH
);

    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 in_valid;
    logic                 cnt_clr;
    logic [WIDTH-1:0]     Sum;
    logic [WIDTH-1:0]     Carry;
    logic [WIDTH-1:0]     sum_q;
    logic [WIDTH-1:0]     carry_q;
    logic                 out_valid;
    logic [CNT_WIDTH-1:0] carry_cnt;

    modport master (
        output A,
        output B,
        output in_valid,
        output cnt_clr,
        input  Sum,
        input  Carry,
        input  sum_q,
        input  carry_q,
        input  out_valid,
        input  carry_cnt
    );

    modport slave (
        input  A,
        input  B,
        input  in_valid,
        input  cnt_clr,
        output Sum,
        output Carry,
        output sum_q,
        output carry_q,
        output out_valid,
        output carry_cnt
    );

endinterface

// File: rtl/half_adder_lane.sv
// One-bit combinational half adder cell.
// Plain operators keep X/Z confined to this lane.
module ha_lane (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;

endmodule

// File: rtl/half_adder.sv
// Vector half adder with a registered, valid-qualified result
// and a saturating count of samples that produced any carry.
module half_adder
    import arith_pkg::*;
#(
    parameter int WIDTH     = HA_WIDTH,
    parameter int CNT_WIDTH = HA_CNT_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    half_adder_if.slave  bus
);

    logic [WIDTH-1:0]     sum_c;
    logic [WIDTH-1:0]     carry_c;

    logic [WIDTH-1:0]     sum_q;
    logic [WIDTH-1:0]     sum_d;
    logic [WIDTH-1:0]     carry_q;
    logic [WIDTH-1:0]     carry_d;
    logic                 valid_q;
    logic                 valid_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 cnt_inc;
    logic                 cnt_sat;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        ha_lane u_lane (
            .a_i (bus.A[i]),
            .b_i (bus.B[i]),
            .s_o (sum_c[i]),
            .c_o (carry_c[i])
        );
    end

    assign bus.Sum   = sum_c;
    assign bus.Carry = carry_c;

    assign cnt_inc = bus.in_valid && (|carry_c);
    assign cnt_sat = &cnt_q;

    always_comb begin
        sum_d   = sum_q;
        carry_d = carry_q;
        valid_d = bus.in_valid;
        cnt_d   = cnt_q;
        if (bus.in_valid) begin
            sum_d   = sum_c;
            carry_d = carry_c;
        end
        // Clear wins over a same-cycle increment.
        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (cnt_inc && !cnt_sat) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.sum_q     = sum_q;
    assign bus.carry_q   = carry_q;
    assign bus.out_valid = valid_q;
    assign bus.carry_cnt = cnt_q;

endmodule

// File: tb/tb_half_adder.sv
// Scoreboard bench for half_adder: directed vectors push expected
// registered results; a negedge monitor pops them on out_valid.
module tb_half_adder;

    logic clk;
    logic rst_n;

    half_adder_if #(.WIDTH(1), .CNT_WIDTH(16)) bus1 ();
    half_adder_if #(.WIDTH(4), .CNT_WIDTH(16)) bus4 ();
    half_adder_if #(.WIDTH(1), .CNT_WIDTH(2))  buss ();

    half_adder #(.WIDTH(1), .CNT_WIDTH(16)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    half_adder #(.WIDTH(4), .CNT_WIDTH(16)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    half_adder #(.WIDTH(1), .CNT_WIDTH(2)) u_duts (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (buss)
    );

    typedef struct packed {
        logic        s;
        logic        c;
        logic [15:0] cnt;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus; an accepted sample queues its result.
    task automatic step(input logic a, input logic b, input logic v,
                        input logic clr, input logic r,
                        input logic es, input logic ec, input int ecnt);
        bus1.A        = a;
        bus1.B        = b;
        bus1.in_valid = v;
        bus1.cnt_clr  = clr;
        rst_n         = r;
        if (v && r) sbq.push_back({es, ec, 16'(ecnt)});
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus1.out_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_valid", 32'(bus1.out_valid), 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("sum_q", 32'(bus1.sum_q), 32'(e.s));
                chk("carry_q", 32'(bus1.carry_q), 32'(e.c));
                chk("carry_cnt", 32'(bus1.carry_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n         = 1'b0;
        bus1.A        = '0;
        bus1.B        = '0;
        bus1.in_valid = 1'b0;
        bus1.cnt_clr  = 1'b0;
        bus4.A        = '0;
        bus4.B        = '0;
        bus4.in_valid = 1'b0;
        bus4.cnt_clr  = 1'b0;
        buss.A        = '0;
        buss.B        = '0;
        buss.in_valid = 1'b0;
        buss.cnt_clr  = 1'b0;

        // Combinational truth table, WIDTH=1.
        bus1.A = 1'b0; bus1.B = 1'b0; #10;
        chk("comb00", {bus1.Sum, bus1.Carry}, 32'b00);
        bus1.A = 1'b1; bus1.B = 1'b0; #10;
        chk("comb10", {bus1.Sum, bus1.Carry}, 32'b10);
        bus1.A = 1'b1; bus1.B = 1'b1; #10;
        chk("comb11", {bus1.Sum, bus1.Carry}, 32'b01);
        bus1.A = 1'b0; bus1.B = 1'b1; #10;
        chk("comb01", {bus1.Sum, bus1.Carry}, 32'b10);

        bus4.A = 4'b1100; bus4.B = 4'b1010; #10;
        chk("w4_sum", 32'(bus4.Sum), 32'b0110);
        chk("w4_carry", 32'(bus4.Carry), 32'b1000);

        // Reset held for two clocks while a carry sample is offered.
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus1.A = 1'b1; bus1.B = 1'b1; bus1.in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sum_q", 32'(bus1.sum_q), 32'd0);
        chk("rst_carry_q", 32'(bus1.carry_q), 32'd0);
        chk("rst_out_valid", 32'(bus1.out_valid), 32'd0);
        chk("rst_cnt", 32'(bus1.carry_cnt), 32'd0);
        chk("rst_comb", {bus1.Sum, bus1.Carry}, 32'b01);

        step(1, 1, 1, 0, 1, 0, 1, 1);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        chk("idle_valid", 32'(bus1.out_valid), 32'd0);
        chk("hold_sum_q", 32'(bus1.sum_q), 32'd0);
        chk("hold_carry_q", 32'(bus1.carry_q), 32'd1);
        chk("hold_cnt", 32'(bus1.carry_cnt), 32'd1);

        step(1, 1, 1, 0, 1, 0, 1, 2);
        step(1, 1, 1, 0, 1, 0, 1, 3);
        step(1, 1, 1, 0, 1, 0, 1, 4);
        step(1, 1, 1, 0, 1, 0, 1, 5);
        step(1, 0, 1, 0, 1, 1, 0, 5);
        step(1, 0, 1, 0, 1, 1, 0, 5);
        step(1, 0, 1, 0, 1, 1, 0, 5);
        chk("cnt_five", 32'(bus1.carry_cnt), 32'd5);

        step(1, 1, 1, 1, 1, 0, 1, 0);
        chk("clr_prio", 32'(bus1.carry_cnt), 32'd0);

        // Reset lands while a fresh sample is being offered.
        step(1, 1, 1, 0, 1, 0, 1, 1);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        chk("mid_rst_valid", 32'(bus1.out_valid), 32'd0);
        chk("mid_rst_cnt", 32'(bus1.carry_cnt), 32'd0);
        chk("mid_rst_sum_q", 32'(bus1.sum_q), 32'd0);
        step(0, 0, 0, 0, 1, 0, 0, 0);

        // Two-bit counter must stop at 3.
        buss.A = 1'b1; buss.B = 1'b1; buss.in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("sat_cnt", 32'(buss.carry_cnt), 32'd3);
        @(posedge clk); #1;
        chk("sat_hold", 32'(buss.carry_cnt), 32'd3);
        buss.in_valid = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
